// File: rtl/stopwatch_pkg.sv
// Shared encodings, digit limits and sizing helper for the stopwatch core.
package stopwatch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam int unsigned MIN_MAX  = 3;
    localparam int unsigned TSEC_MAX = 5;
    localparam int unsigned DIG_MAX  = 9;

    localparam int unsigned MIN_W = 2;
    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_RUN   = RUN,
        S_PAUSE = PAUSE
    } state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button inputs and display-mux outputs of the stopwatch core.
interface stopwatch_core_if;
    import stopwatch_pkg::*;

    logic             start_btn;
    logic             clr_btn;
    logic [1:0]       select;
    logic [MIN_W-1:0] en0;
    logic [DIG_W-1:0] en1;
    logic [DIG_W-1:0] en2;
    logic [DIG_W-1:0] en3;
    logic             running;
    logic             ovf;

    modport master (
        output start_btn, clr_btn,
        input  select, en0, en1, en2, en3, running, ovf
    );

    modport slave (
        input  start_btn, clr_btn,
        output select, en0, en1, en2, en3, running, ovf
    );

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so a chain ripples in one cycle.
module bcd_digit #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o,
    output logic         carry_c_o
);

    logic [W-1:0] q_q, q_d;
    logic         at_max_c;

    assign at_max_c  = (q_q == W'(MAX));
    assign carry_c_o = inc_i & at_max_c;
    assign q_o       = q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = at_max_c ? '0 : q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Start/pause/clear stopwatch counting M:SS.t in BCD plus the free-running digit-scan select.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_core_if.slave bus
);

    localparam int unsigned TICK_W = cnt_width(TICK_DIV);
    localparam int unsigned SCAN_W = cnt_width(SCAN_DIV);

    logic [2:0]        start_sync_q, clr_sync_q;
    logic              start_ev_c, clr_ev_c;
    state_e            state_q, state_d;
    logic              running_q;
    logic              ovf_q, ovf_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_c;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        select_q, select_d;
    logic [3:0]        carry_c;

    // Two synchronizer stages, third stage only remembers the previous level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            clr_sync_q   <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], bus.start_btn};
            clr_sync_q   <= {clr_sync_q[1:0], bus.clr_btn};
        end
    end

    assign start_ev_c = start_sync_q[1] & ~start_sync_q[2];
    assign clr_ev_c   = clr_sync_q[1] & ~clr_sync_q[2];
    assign tick_c     = (state_q == S_RUN) && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        select_d   = select_q;
        ovf_d      = carry_c[0] & ~clr_ev_c;

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            select_d   = select_q + 2'd1;
        end

        // Clear outranks a simultaneous start press.
        if (clr_ev_c) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
        end else begin
            if (state_q == S_RUN) begin
                tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
            end
            if (start_ev_c) begin
                case (state_q)
                    S_IDLE:  state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            running_q  <= 1'b0;
            ovf_q      <= 1'b0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            select_q   <= '0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == S_RUN);
            ovf_q      <= ovf_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            select_q   <= select_d;
        end
    end

    // Digit chain: tenths -> seconds -> tens of seconds -> minutes.
    bcd_digit #(.W(DIG_W), .MAX(DIG_MAX)) u_tenths (
        .clk, .rst_n, .inc_i(tick_c), .clr_i(clr_ev_c),
        .q_o(bus.en3), .carry_c_o(carry_c[3])
    );

    bcd_digit #(.W(DIG_W), .MAX(DIG_MAX)) u_secs (
        .clk, .rst_n, .inc_i(carry_c[3]), .clr_i(clr_ev_c),
        .q_o(bus.en2), .carry_c_o(carry_c[2])
    );

    bcd_digit #(.W(DIG_W), .MAX(TSEC_MAX)) u_tsecs (
        .clk, .rst_n, .inc_i(carry_c[2]), .clr_i(clr_ev_c),
        .q_o(bus.en1), .carry_c_o(carry_c[1])
    );

    bcd_digit #(.W(MIN_W), .MAX(MIN_MAX)) u_mins (
        .clk, .rst_n, .inc_i(carry_c[1]), .clr_i(clr_ev_c),
        .q_o(bus.en0), .carry_c_o(carry_c[0])
    );

    assign bus.select  = select_q;
    assign bus.running = running_q;
    assign bus.ovf     = ovf_q;

endmodule
